// File: rtl/data_rx.sv
// Deserializing receiver for the multi-line frontend link: locks to the idle code,
// detects start codes and reassembles the following data chunks into one word.
module data_rx #(
  parameter int LENGTH     = 128,
  parameter int LINES      = 3,
  parameter int LOCK_COUNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINES-1:0]  d,
  output logic              valid,
  output logic [LENGTH-1:0] data_out,
  output logic              locked,
  output logic              err
);

  localparam int CHUNK_LEN      = 4 * LINES;
  localparam int LENGTH_NXT     = ((LENGTH + CHUNK_LEN - 1) / CHUNK_LEN) * CHUNK_LEN;
  localparam int CHUNK_PER_DATA = LENGTH_NXT / CHUNK_LEN;
  localparam int CNT_W          = $clog2(LOCK_COUNT + 1);
  localparam int CHK_W          = $clog2(CHUNK_PER_DATA + 1);
  localparam int ASM_W          = LENGTH - LINES;

  localparam logic [CHUNK_LEN-1:0] IDLE_CODE  = {{(2*LINES){1'b1}}, {(2*LINES){1'b0}}};
  localparam logic [CHUNK_LEN-1:0] START_CODE = {{LINES{1'b1}}, {LINES{1'b0}},
                                                 {LINES{1'b1}}, {LINES{1'b0}}};
  localparam logic [CNT_W-1:0]     LOCK_TGT   = CNT_W'(LOCK_COUNT);
  localparam logic [CHK_W-1:0]     LAST_CHUNK = CHK_W'(CHUNK_PER_DATA - 1);

  typedef enum logic [1:0] {
    SEARCH,
    LOCKED,
    DATA
  } state_t;

  state_t             state, state_nxt;
  logic [LINES-1:0]   d_q;
  logic [CHUNK_LEN-1:0] win;
  logic [1:0]         ph, ph_nxt;
  logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt, cnt_inc;
  logic [CHK_W-1:0]   chunk_cnt, chunk_cnt_nxt;
  logic [ASM_W-1:0]   asm_q;
  logic [LENGTH-1:0]  word;
  logic               valid_nxt, err_nxt, load_word, shift_en;
  logic               boundary, is_idle, is_start;

  assign boundary = (ph == 2'd3);
  assign is_idle  = (win == IDLE_CODE);
  assign is_start = (win == START_CODE);
  assign cnt_inc  = lock_cnt + CNT_W'(1);
  assign locked   = (state != SEARCH);

  // Only the low LENGTH bits of the padded word are kept; the leading pad beats
  // simply shift out of the top of the assembly register and are never seen.
  assign word = {asm_q, win[LINES-1:0]};

  // NOTE: every sequential register uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q       <= '0;
      win       <= '0;
      ph        <= '0;
      state     <= SEARCH;
      lock_cnt  <= '0;
      chunk_cnt <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      data_out  <= '0;
    end else begin
      d_q       <= d;
      win       <= {win[CHUNK_LEN-LINES-1:0], d_q};
      ph        <= ph_nxt;
      state     <= state_nxt;
      lock_cnt  <= lock_cnt_nxt;
      chunk_cnt <= chunk_cnt_nxt;
      valid     <= valid_nxt;
      err       <= err_nxt;
      if (load_word) data_out <= word;
    end
  end

  // NOTE: the assembly register is pure datapath, fully rewritten by the data
  // beats of every word before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (shift_en) asm_q <= word[ASM_W-1:0];
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    ph_nxt        = ph + 2'd1;
    lock_cnt_nxt  = lock_cnt;
    chunk_cnt_nxt = chunk_cnt;
    valid_nxt     = 1'b0;
    err_nxt       = 1'b0;
    load_word     = 1'b0;
    shift_en      = 1'b0;

    case (state)
      SEARCH: begin
        // Until a first idle is found every cycle is a candidate boundary.
        if (lock_cnt == '0 || boundary) begin
          if (is_idle) begin
            ph_nxt       = '0;
            lock_cnt_nxt = cnt_inc;
            if (cnt_inc == LOCK_TGT) state_nxt = LOCKED;
          end else begin
            lock_cnt_nxt = '0;
          end
        end
      end

      LOCKED: begin
        if (boundary) begin
          if (is_start) begin
            state_nxt     = DATA;
            chunk_cnt_nxt = '0;
          end else if (!is_idle) begin
            state_nxt    = SEARCH;
            lock_cnt_nxt = '0;
            err_nxt      = 1'b1;
          end
        end
      end

      DATA: begin
        shift_en = 1'b1;
        if (boundary) begin
          if (chunk_cnt == LAST_CHUNK) begin
            load_word = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = LOCKED;
          end else begin
            chunk_cnt_nxt = chunk_cnt + CHK_W'(1);
          end
        end
      end

      default: state_nxt = SEARCH;
    endcase
  end

endmodule

// File: tb/tb_data_rx.sv
// Directed bench for data_rx: lock acquisition, word reception, back-to-back
// words, phase search, framing loss and mid-word reset.
module tb_data_rx;

  localparam int LENGTH = 128;
  localparam int LINES  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [LINES-1:0]  d   = '0;
  logic              valid;
  logic [LENGTH-1:0] data_out;
  logic              locked;
  logic              err;

  int errors = 0;
  int checks = 0;

  // Monitor state, written only by the monitor process.
  int cyc        = 0;
  int valid_cnt  = 0;
  int err_cnt    = 0;
  int both_cnt   = 0;
  int lock_cyc   = -1;
  int err_cyc    = -1;
  logic locked_prev = 1'b0;
  logic [LENGTH-1:0] vlog_data [16];
  int                vlog_cyc  [16];

  data_rx #(.LENGTH(LENGTH), .LINES(LINES), .LOCK_COUNT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .d        (d),
    .valid    (valid),
    .data_out (data_out),
    .locked   (locked),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vlog_data[valid_cnt % 16] = data_out;
      vlog_cyc[valid_cnt % 16]  = cyc;
      valid_cnt = valid_cnt + 1;
    end
    if (err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (valid && err) both_cnt = both_cnt + 1;
    if (locked && !locked_prev) lock_cyc = cyc;
    locked_prev = locked;
  end

  localparam logic [127:0] W0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] W1 = 128'hDEAD_BEEF_0000_FFFF_A5A5_5A5A_1234_5678;
  localparam logic [127:0] W2 = 128'h8000_0000_0000_0001_7FFF_FFFF_FFFF_FFFE;
  localparam logic [127:0] W3 = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

  task automatic drive(input logic [2:0] v);
    d = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_chunk(input logic [2:0] b0, input logic [2:0] b1,
                            input logic [2:0] b2, input logic [2:0] b3);
    drive(b0); drive(b1); drive(b2); drive(b3);
  endtask

  // Sends n idle chunks and returns the edge of the last beat of the first one.
  task automatic send_idles(input int n, output int first_last_edge);
    first_last_edge = -1;
    for (int i = 0; i < n; i++) begin
      send_chunk(3'd7, 3'd7, 3'd0, 3'd0);
      if (i == 0) first_last_edge = cyc;
    end
  endtask

  // START code then 44 beats, MSB-first, of {pad, w}.
  task automatic send_word(input logic [127:0] w, input logic [3:0] pad,
                           output int last_edge);
    logic [131:0] p;
    p = {pad, w};
    send_chunk(3'd7, 3'd0, 3'd7, 3'd0);
    for (int k = 0; k < 44; k++) drive(p[131 - 3*k -: 3]);
    last_edge = cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(3'd0);
    drive(3'd0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(3'd5);
    drive(3'd7);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    d = '0;
    drive(3'd0);
    rst = 1'b0;
  endtask

  task automatic test_lock();
    int l0, v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_idles(6, l0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_locked: got %b want 1", locked); end
    checks++; if (lock_cyc !== l0 + 14) begin errors++; $display("FAIL lock_time: got %0d want %0d", lock_cyc, l0 + 14); end
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL lock_no_valid: got %0d pulses want 0", valid_cnt - v0); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL lock_no_err: got %0d pulses want 0", err_cnt - e0); end
  endtask

  task automatic test_word();
    int n, v0, e0, dummy;
    v0 = valid_cnt; e0 = err_cnt;
    send_word(W0, 4'h0, n);
    send_idles(2, dummy);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL word_count: got %0d want 1", valid_cnt - v0); end
    checks++; if (vlog_data[v0 % 16] !== W0) begin errors++; $display("FAIL word_data: got %h want %h", vlog_data[v0 % 16], W0); end
    checks++; if (vlog_cyc[v0 % 16] !== n + 2) begin errors++; $display("FAIL word_latency: got %0d want %0d", vlog_cyc[v0 % 16], n + 2); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL word_no_err: got %0d want 0", err_cnt - e0); end
    checks++; if (data_out !== W0) begin errors++; $display("FAIL word_hold: got %h want %h", data_out, W0); end
  endtask

  task automatic test_back_to_back();
    int n1, n2, v0, dummy;
    v0 = valid_cnt;
    send_word(W1, 4'h0, n1);
    send_word(W2, 4'h0, n2);
    send_idles(2, dummy);
    checks++; if (valid_cnt !== v0 + 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", valid_cnt - v0); end
    checks++; if (vlog_data[v0 % 16] !== W1) begin errors++; $display("FAIL b2b_data_a: got %h want %h", vlog_data[v0 % 16], W1); end
    checks++; if (vlog_data[(v0 + 1) % 16] !== W2) begin errors++; $display("FAIL b2b_data_b: got %h want %h", vlog_data[(v0 + 1) % 16], W2); end
    checks++; if (vlog_cyc[v0 % 16] !== n1 + 2) begin errors++; $display("FAIL b2b_latency_a: got %0d want %0d", vlog_cyc[v0 % 16], n1 + 2); end
    checks++; if (vlog_cyc[(v0 + 1) % 16] - vlog_cyc[v0 % 16] !== 48) begin
      errors++; $display("FAIL b2b_spacing: got %0d want 48", vlog_cyc[(v0 + 1) % 16] - vlog_cyc[v0 % 16]);
    end
  endtask

  task automatic test_pad_discard();
    int n, v0, dummy;
    v0 = valid_cnt;
    send_word(W3, 4'hF, n);
    send_idles(1, dummy);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL pad_count: got %0d want 1", valid_cnt - v0); end
    checks++; if (vlog_data[v0 % 16] !== W3) begin errors++; $display("FAIL pad_data: got %h want %h", vlog_data[v0 % 16], W3); end
  endtask

  task automatic test_phase();
    int l0;
    for (int p = 0; p < 4; p++) begin
      do_reset();
      send_chunk(3'd7, 3'd0, 3'd7, 3'd0);
      send_chunk(3'd7, 3'd0, 3'd7, 3'd0);
      for (int i = 0; i < p; i++) drive(3'd5);
      send_idles(6, l0);
      checks++; if (lock_cyc !== l0 + 14 || locked !== 1'b1) begin
        errors++; $display("FAIL phase%0d_lock: got cycle %0d locked %b want cycle %0d locked 1", p, lock_cyc, locked, l0 + 14);
      end
    end
  endtask

  task automatic test_err();
    int e0, v0, l0, n;
    e0 = err_cnt;
    send_chunk(3'd7, 3'd7, 3'd7, 3'd7);
    l0 = cyc;
    drive(3'd7);
    drive(3'd7);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b want 1", err); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL err_unlock: got %b want 0", locked); end
    drive(3'd0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b want 0", err); end
    drive(3'd0);
    send_idles(6, n);
    checks++; if (err_cnt !== e0 + 1 || err_cyc !== l0 + 2) begin
      errors++; $display("FAIL err_timing: got %0d pulses at %0d want 1 at %0d", err_cnt - e0, err_cyc, l0 + 2);
    end
    // The idle chunk started during the err beats completes at l0+4.
    checks++; if (lock_cyc !== l0 + 4 + 14) begin errors++; $display("FAIL err_relock: got %0d want %0d", lock_cyc, l0 + 18); end
    v0 = valid_cnt;
    send_word(W1, 4'h0, n);
    send_idles(1, l0);
    checks++; if (valid_cnt !== v0 + 1 || vlog_data[v0 % 16] !== W1) begin
      errors++; $display("FAIL err_next_word: got %0d pulses data %h want 1 data %h", valid_cnt - v0, vlog_data[v0 % 16], W1);
    end
  endtask

  task automatic test_reset_mid_word();
    int v0, l0, n;
    logic [131:0] p;
    v0 = valid_cnt;
    p  = {4'h0, W2};
    send_chunk(3'd7, 3'd0, 3'd7, 3'd0);
    for (int k = 0; k < 22; k++) drive(p[131 - 3*k -: 3]);
    rst = 1'b1;
    drive(3'd0);
    checks++; if (valid !== 1'b0 || err !== 1'b0 || locked !== 1'b0 || data_out !== '0) begin
      errors++; $display("FAIL midrst_outputs: got valid %b err %b locked %b data %h want all 0", valid, err, locked, data_out);
    end
    drive(3'd0);
    rst = 1'b0;
    send_idles(6, l0);
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL midrst_no_valid: got %0d pulses want 0", valid_cnt - v0); end
    checks++; if (lock_cyc !== l0 + 14) begin errors++; $display("FAIL midrst_relock: got %0d want %0d", lock_cyc, l0 + 14); end
    send_word(W0, 4'h0, n);
    send_idles(1, l0);
    checks++; if (valid_cnt !== v0 + 1 || vlog_data[v0 % 16] !== W0) begin
      errors++; $display("FAIL midrst_next_word: got %0d pulses data %h want 1 data %h", valid_cnt - v0, vlog_data[v0 % 16], W0);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_word();
    test_back_to_back();
    test_pad_discard();
    test_phase();
    test_err();
    test_reset_mid_word();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL valid_err_overlap: got %0d want 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_rx.md
# data_rx

Deserializing receiver for the multi-line frontend link; it sits directly downstream of the `data_tx` serializer. It locks to the transmitter's idle code to recover chunk framing and detects start codes. Each start code is followed by a fixed number of data chunks, which the block reassembles into a LENGTH-bit word and presents with a one-cycle valid pulse.

## Interface
- LENGTH, 128: payload bits per word; must match the transmitter.
- LINES, 3: number of physical data lines.
- LOCK_COUNT, 4: consecutive correctly-phased idle codes required to declare lock (≥1).
- clk  input  1  link clock, same clock as the transmitter (source-synchronous); all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- d  input  LINES  line samples, one beat per clock.
- valid  output  1  one-cycle pulse; data_out holds a new word.
- data_out  output  LENGTH  received payload; holds its value between pulses.
- locked  output  1  framing acquired.
- err  output  1  one-cycle pulse on framing loss.

## Operation
- Protocol constants:
  - CHUNK_LEN = 4*LINES; a chunk is 4 beats, sent MSB-first, LINES bits per beat.
  - LENGTH_NXT = LENGTH rounded up to a multiple of CHUNK_LEN.
  - CHUNK_PER_DATA = LENGTH_NXT/CHUNK_LEN.
  - IDLE_CODE beats: all-ones, all-ones, all-zeros, all-zeros.
  - START_CODE beats: all-ones, all-zeros, all-ones, all-zeros.
- Input path: d is registered once into d_q. Window register win (CHUNK_LEN bits) shifts left by LINES and loads d_q in its low bits every cycle. win therefore always holds the last 4 beats, oldest beat in the MSBs.
- Phase counter ph (2 bits) counts 0..3. A chunk boundary is the cycle where win holds a complete aligned chunk, i.e. ph==3.
- States:
  - SEARCH: ph is ignored. When win==IDLE_CODE, force ph so this cycle is a boundary and set lock count = 1. At each later boundary, win==IDLE_CODE increments the count and any other value returns the count to 0 (stay SEARCH). When the count reaches LOCK_COUNT, go to LOCKED. Only the correct phase matches, because no rotation of IDLE_CODE equals IDLE_CODE or START_CODE.
  - LOCKED (locked=1): at each boundary:
    - IDLE_CODE: stay.
    - START_CODE: go to DATA and clear the chunk counter.
    - anything else: pulse err, go to SEARCH, clear the lock count.
  - DATA (locked=1): no code checks. Each beat of d_q shifts into a LENGTH_NXT-bit assembly register. After CHUNK_PER_DATA*4 beats:
    - load data_out with the low LENGTH bits of the assembly register (the upper LENGTH_NXT-LENGTH pad bits are discarded unchecked);
    - pulse valid;
    - return to LOCKED.
  - The beat immediately after the last data beat starts a new chunk, so a START_CODE directly following data (back-to-back words) is accepted without an intervening idle.
- No backpressure. Every completed word is presented exactly once.

## Timing
- Reset values: valid=0, data_out=0, locked=0, err=0, state SEARCH, lock count 0, ph 0, win 0, d_q 0.
- Reset mid-word discards the partial word; no valid pulse follows.
- Latency: the last data beat is sampled from d at edge N; valid=1 and data_out update after edge N+2. valid stays high for exactly one cycle.
- Throughput: one word per (CHUNK_PER_DATA+1)*4 cycles maximum.
- err is high for one cycle, registered on the boundary where the bad code is seen. locked falls on the same edge.
- Lock: first locked=1 occurs LOCK_COUNT*4 − 3 cycles after the first full idle code enters win, assuming an uninterrupted idle stream.
- valid and err are never high in the same cycle. err only occurs in LOCKED.

## Test plan
- LINES=3, LENGTH=128 (CHUNK_PER_DATA=11). Drive a continuous d = 7,7,0,0 stream from reset → locked rises after the 4th aligned idle; valid=0; err=0.
- After lock: send START (7,0,7,0), then 44 beats carrying word 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, zero-padded in the top 4 bits → one valid pulse 2 cycles after the last beat, with data_out equal to that word.
- Send two words back-to-back (START, data, START, data) with no idle between → two valid pulses, 48 cycles apart, with correct values.
- Start the idle stream at each of the 4 beat phases, with a garbage prefix → lock at the correct phase in every case; no false lock on rotations of 7,0,7,0.
- While locked, inject a boundary chunk of 7,7,7,7 → err pulses once, locked=0; relock after 4 idles, and the next word is received correctly.
- Assert rst halfway through a word's data beats → all outputs return to reset values; no valid for the truncated word; normal relock afterwards.
